// File: rtl/alu_decode_stage.sv
// alu_decode_stage: registered RV32I decode stage between fetch and execute.
// Turns one 32-bit instruction into the ALU control word, operand selects,
// immediate, register indices and class flags, held in a one-entry register.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. valid never depends on ready; once out_valid
// is raised the entry and every output stay bit-exact until out_ready takes
// it. in_ready = !out_valid || out_ready, purely combinational, so a drain
// and a new capture may share one edge (no bubble). flush kills the held
// entry and blocks any capture on that edge.
module alu_decode_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      alu_control,
  output logic [1:0]      op1_sel,
  output logic [1:0]      op2_sel,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic            is_branch,
  output logic            is_load,
  output logic            is_store,
  output logic            is_jump,
  output logic            illegal
);

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_XOR    = 4'b0011;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_SLT    = 4'b0111;
  localparam logic [3:0] ALU_SLL    = 4'b1000;
  localparam logic [3:0] ALU_SRL    = 4'b1001;
  localparam logic [3:0] ALU_SRA    = 4'b1010;
  localparam logic [3:0] ALU_SLTU   = 4'b1011;
  localparam logic [3:0] ALU_PASS_B = 4'b1101;

  localparam logic [1:0] OP1_RS1  = 2'b00;
  localparam logic [1:0] OP1_PC   = 2'b01;
  localparam logic [1:0] OP1_ZERO = 2'b10;
  localparam logic [1:0] OP2_RS2  = 2'b00;
  localparam logic [1:0] OP2_IMM  = 2'b01;
  localparam logic [1:0] OP2_FOUR = 2'b10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
  // Shift-immediates carry only the 5-bit shamt; funct7 is not part of it.
  assign imm_sh = {27'b0, in_instr[24:20]};

  assign in_ready = !out_valid || out_ready;

  logic            accept;
  assign accept = in_valid && in_ready && !flush;

  logic [3:0]      d_alu;
  logic [1:0]      d_op1, d_op2;
  logic [XLEN-1:0] d_imm;
  logic [4:0]      d_rs1;
  logic            d_wr, d_br, d_ld, d_st, d_jp, d_bad;

  // Combinational decode of the incoming instruction; illegal cases are
  // normalised at the end so no class flag or write leaks through.
  always_comb begin
    d_alu = ALU_ADD;
    d_op1 = OP1_RS1;
    d_op2 = OP2_RS2;
    d_imm = '0;
    d_rs1 = in_instr[19:15];
    d_wr  = 1'b0;
    d_br  = 1'b0;
    d_ld  = 1'b0;
    d_st  = 1'b0;
    d_jp  = 1'b0;
    d_bad = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        d_wr = 1'b1;
        unique case (funct3)
          3'b000: begin
            if (funct7 == F7_ZERO)     d_alu = ALU_ADD;
            else if (funct7 == F7_ALT) d_alu = ALU_SUB;
            else                       d_bad = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_ZERO)     d_alu = ALU_SRL;
            else if (funct7 == F7_ALT) d_alu = ALU_SRA;
            else                       d_bad = 1'b1;
          end
          3'b001: begin d_alu = ALU_SLL;  d_bad = (funct7 != F7_ZERO); end
          3'b010: begin d_alu = ALU_SLT;  d_bad = (funct7 != F7_ZERO); end
          3'b011: begin d_alu = ALU_SLTU; d_bad = (funct7 != F7_ZERO); end
          3'b100: begin d_alu = ALU_XOR;  d_bad = (funct7 != F7_ZERO); end
          3'b110: begin d_alu = ALU_OR;   d_bad = (funct7 != F7_ZERO); end
          default: begin d_alu = ALU_AND; d_bad = (funct7 != F7_ZERO); end
        endcase
      end
      OPC_OP_IMM: begin
        d_wr  = 1'b1;
        d_op2 = OP2_IMM;
        d_imm = imm_i;
        unique case (funct3)
          3'b000: d_alu = ALU_ADD;
          3'b010: d_alu = ALU_SLT;
          3'b011: d_alu = ALU_SLTU;
          3'b100: d_alu = ALU_XOR;
          3'b110: d_alu = ALU_OR;
          3'b111: d_alu = ALU_AND;
          3'b001: begin
            d_alu = ALU_SLL;
            d_imm = imm_sh;
            d_bad = (funct7 != F7_ZERO);
          end
          default: begin
            d_imm = imm_sh;
            if (funct7 == F7_ZERO)     d_alu = ALU_SRL;
            else if (funct7 == F7_ALT) d_alu = ALU_SRA;
            else                       d_bad = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        d_alu = ALU_PASS_B;
        d_op1 = OP1_ZERO;
        d_op2 = OP2_IMM;
        d_imm = imm_u;
        d_rs1 = 5'd0;
        d_wr  = 1'b1;
      end
      OPC_AUIPC: begin
        d_op1 = OP1_PC;
        d_op2 = OP2_IMM;
        d_imm = imm_u;
        d_wr  = 1'b1;
      end
      OPC_JAL: begin
        d_op1 = OP1_PC;
        d_op2 = OP2_FOUR;
        d_imm = imm_j;
        d_wr  = 1'b1;
        d_jp  = 1'b1;
      end
      OPC_JALR: begin
        d_op1 = OP1_PC;
        d_op2 = OP2_FOUR;
        d_imm = imm_i;
        d_wr  = 1'b1;
        d_jp  = 1'b1;
        d_bad = (funct3 != 3'b000);
      end
      OPC_LOAD: begin
        d_op2 = OP2_IMM;
        d_imm = imm_i;
        d_wr  = 1'b1;
        d_ld  = 1'b1;
        d_bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        d_op2 = OP2_IMM;
        d_imm = imm_s;
        d_st  = 1'b1;
        d_bad = (funct3[2] == 1'b1) || (funct3 == 3'b011);
      end
      OPC_BRANCH: begin
        d_imm = imm_b;
        d_br  = 1'b1;
        unique case (funct3[2:1])
          2'b00:   d_alu = ALU_SUB;
          2'b10:   d_alu = ALU_SLT;
          2'b11:   d_alu = ALU_SLTU;
          default: d_bad = 1'b1;
        endcase
      end
      default: d_bad = 1'b1;
    endcase
    if (d_bad) begin
      d_alu = ALU_ADD;
      d_op1 = OP1_RS1;
      d_op2 = OP2_RS2;
      d_imm = '0;
      d_wr  = 1'b0;
      d_br  = 1'b0;
      d_ld  = 1'b0;
      d_st  = 1'b0;
      d_jp  = 1'b0;
    end
    // x0 is never written, whatever the opcode says.
    if (in_instr[11:7] == 5'd0) d_wr = 1'b0;
  end

  // Output register: flush beats capture, capture beats drain; data only
  // moves on capture so a stalled entry stays bit-exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= RESET_PC;
      alu_control <= '0;
      op1_sel     <= '0;
      op2_sel     <= '0;
      imm         <= '0;
      rs1_addr    <= '0;
      rs2_addr    <= '0;
      rd_addr     <= '0;
      reg_write   <= 1'b0;
      is_branch   <= 1'b0;
      is_load     <= 1'b0;
      is_store    <= 1'b0;
      is_jump     <= 1'b0;
      illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      alu_control <= d_alu;
      op1_sel     <= d_op1;
      op2_sel     <= d_op2;
      imm         <= d_imm;
      rs1_addr    <= d_rs1;
      rs2_addr    <= in_instr[24:20];
      rd_addr     <= in_instr[11:7];
      reg_write   <= d_wr;
      is_branch   <= d_br;
      is_load     <= d_ld;
      is_store    <= d_st;
      is_jump     <= d_jp;
      illegal     <= d_bad;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed vectors for the decode stage. Expected
// decode words are hand-computed constants pushed when an instruction is
// issued; a negedge monitor pops one per accepted output entry.
module tb_alu_decode_stage;

  localparam int          W        = 93;
  localparam logic [31:0] RESET_PC = 32'hDEAD_BEE0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [3:0]  alu_control;
  logic [1:0]  op1_sel, op2_sel;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        reg_write, is_branch, is_load, is_store, is_jump, illegal;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] act;
  int           n_vec = 0;
  int           n_err = 0;

  alu_decode_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_control(alu_control), .op1_sel(op1_sel), .op2_sel(op2_sel),
    .imm(imm), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .reg_write(reg_write), .is_branch(is_branch), .is_load(is_load),
    .is_store(is_store), .is_jump(is_jump), .illegal(illegal)
  );

  // Clock generation.
  always #5 clk = ~clk;

  assign act = {out_pc, alu_control, op1_sel, op2_sel, imm, rs1_addr,
                rs2_addr, rd_addr, reg_write, is_branch, is_load, is_store,
                is_jump, illegal};

  // fl = {reg_write, is_branch, is_load, is_store, is_jump, illegal}
  function automatic logic [W-1:0] mk(input logic [31:0] pc,
      input logic [3:0] alu, input logic [1:0] o1, input logic [1:0] o2,
      input logic [31:0] im, input logic [4:0] r1, input logic [4:0] r2,
      input logic [4:0] rd, input logic [5:0] fl);
    return {pc, alu, o1, o2, im, r1, r2, rd, fl};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Scoreboard monitor: every accepted output entry is compared in order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_entry: got %h expected none", act);
      end else begin
        chk("decode", act, exp_q.pop_front());
      end
    end
  end

  // Driver: present one instruction and hold it until it is captured.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
      input logic [W-1:0] e, input bit push, output int stalls);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    if (push) exp_q.push_back(e);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 20) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected capture", stalls);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0]  instr;
    logic [31:0]  pc;
    logic [W-1:0] e;
  } vec_t;

  vec_t vecs[13];
  int   st;

  initial begin
    vecs[0]  = '{32'h002081B3, 32'h100, mk(32'h100, 4'b0010, 2'd0, 2'd0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b100000)};
    vecs[1]  = '{32'h402081B3, 32'h104, mk(32'h104, 4'b0110, 2'd0, 2'd0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b100000)};
    vecs[2]  = '{32'h40335293, 32'h108, mk(32'h108, 4'b1010, 2'd0, 2'd1, 32'h3, 5'd6, 5'd3, 5'd5, 6'b100000)};
    vecs[3]  = '{32'hFFF00093, 32'h10C, mk(32'h10C, 4'b0010, 2'd0, 2'd1, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1, 6'b100000)};
    vecs[4]  = '{32'h123450B7, 32'h110, mk(32'h110, 4'b1101, 2'd2, 2'd1, 32'h12345000, 5'd0, 5'd3, 5'd1, 6'b100000)};
    vecs[5]  = '{32'h00000013, 32'h114, mk(32'h114, 4'b0010, 2'd0, 2'd1, 32'h0, 5'd0, 5'd0, 5'd0, 6'b000000)};
    vecs[6]  = '{32'h002081FF, 32'h118, mk(32'h118, 4'b0010, 2'd0, 2'd0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b000001)};
    vecs[7]  = '{32'h0020C463, 32'h11C, mk(32'h11C, 4'b0111, 2'd0, 2'd0, 32'h8, 5'd1, 5'd2, 5'd8, 6'b010000)};
    vecs[8]  = '{32'h0020A623, 32'h120, mk(32'h120, 4'b0010, 2'd0, 2'd1, 32'hC, 5'd1, 5'd2, 5'd12, 6'b000100)};
    vecs[9]  = '{32'hFFC0A283, 32'h124, mk(32'h124, 4'b0010, 2'd0, 2'd1, 32'hFFFFFFFC, 5'd1, 5'd28, 5'd5, 6'b101000)};
    vecs[10] = '{32'h010000EF, 32'h128, mk(32'h128, 4'b0010, 2'd1, 2'd2, 32'h10, 5'd0, 5'd16, 5'd1, 6'b100010)};
    vecs[11] = '{32'h4020E1B3, 32'h12C, mk(32'h12C, 4'b0010, 2'd0, 2'd0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b000001)};
    vecs[12] = '{32'h00001117, 32'h130, mk(32'h130, 4'b0010, 2'd1, 2'd1, 32'h1000, 5'd0, 5'd0, 5'd2, 6'b100000)};
  end

  // Main sequence: reset, directed vectors, backpressure, flush, reset.
  initial begin : main
    logic [W-1:0] exp_a, exp_b, exp_c;
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("reset_state", act, mk(RESET_PC, 4'd0, 2'd0, 2'd0, 32'd0, 5'd0, 5'd0, 5'd0, 6'd0));
    chk("reset_valid", {92'd0, out_valid}, '0);
    chk("reset_in_ready", {92'd0, in_ready}, {92'd0, 1'b1});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD then SUB back to back: the second must not stall.
    send(vecs[0].instr, vecs[0].pc, vecs[0].e, 1'b1, st);
    send(vecs[1].instr, vecs[1].pc, vecs[1].e, 1'b1, st);
    chk("no_bubble_stalls", {61'd0, st}, '0);
    for (int i = 2; i < 13; i++) send(vecs[i].instr, vecs[i].pc, vecs[i].e, 1'b1, st);
    repeat (2) @(negedge clk);
    chk("drained_valid", {92'd0, out_valid}, '0);

    // Backpressure: hold A for 3 cycles while B waits at the input.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_a = mk(32'h200, 4'b0010, 2'd0, 2'd0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b100000);
    exp_b = mk(32'h204, 4'b0110, 2'd0, 2'd0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b100000);
    send(32'h002081B3, 32'h200, exp_a, 1'b1, st);
    in_valid = 1'b1;
    in_instr = 32'h402081B3;
    in_pc    = 32'h204;
    exp_q.push_back(exp_b);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready", {92'd0, in_ready}, '0);
      chk("bp_frozen", act, exp_a);
      chk("bp_valid", {92'd0, out_valid}, {92'd0, 1'b1});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_b_captured", act, exp_b);
    @(posedge clk);
    #1;

    // Flush: held JAL and incoming ADD are both discarded.
    out_ready = 1'b0;
    exp_c = mk(32'h300, 4'b0010, 2'd1, 2'd2, 32'h10, 5'd0, 5'd16, 5'd1, 6'b100010);
    send(32'h010000EF, 32'h300, exp_c, 1'b0, st);
    chk("pre_flush_entry", act, exp_c);
    in_valid = 1'b1;
    in_instr = 32'h002081B3;
    in_pc    = 32'h304;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", {92'd0, out_valid}, '0);
    @(negedge clk);
    chk("flush_no_capture", {92'd0, out_valid}, '0);
    @(posedge clk);
    #1;

    // Reset mid-stream while an entry is stalled.
    send(32'h123450B7, 32'h400, '0, 1'b0, st);
    chk("pre_reset_valid", {92'd0, out_valid}, {92'd0, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_valid", {92'd0, out_valid}, '0);
    chk("async_reset_pc", {61'd0, out_pc}, {61'd0, RESET_PC});
    chk("async_reset_alu", {89'd0, alu_control}, '0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("queue_empty", {61'd0, exp_q.size()}, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Registered decode stage that converts a 32-bit RV32I instruction into the ALU control word, operand selects and immediate used by the integer ALU.
- Sits between fetch and execute, with a valid/ready handshake on both sides.
- Produces the exact 4-bit alu_control encoding the ALU consumes.

Parameters:
- XLEN, 32, datapath/instruction/PC width (only 32 supported).
- RESET_PC, 32'h0000_0000, value driven on out_pc during reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  instruction/PC valid from fetch.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  raw instruction.
- in_pc  input  32  instruction PC.
- flush  input  1  synchronous kill of the held entry and of the current input.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  execute accepts entry.
- out_pc  output  32  registered PC.
- alu_control  output  4  0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT, 1000 SLL, 1001 SRL, 1010 SRA, 1011 SLTU, 1100 PASS_A, 1101 PASS_B.
- op1_sel  output  2  00 rs1, 01 pc, 10 zero.
- op2_sel  output  2  00 rs2, 01 imm, 10 constant 4.
- imm  output  32  sign-extended immediate (I/S/B/U/J format per opcode).
- rs1_addr, rs2_addr, rd_addr  output  5 each  register indices.
- reg_write  output  1  writes rd (forced 0 when rd==0).
- is_branch, is_load, is_store, is_jump  output  1 each  class flags.
- illegal  output  1  undecodable instruction.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_pc=RESET_PC, all other outputs 0. Deassertion is synchronous to clk.
- in_ready = !out_valid || out_ready. This is combinational and does not depend on in_valid.
- Capture: on a clk edge with in_valid && in_ready && !flush, register the decode of in_instr/in_pc and set out_valid=1. Latency is 1 cycle.
- Drain: on out_valid && out_ready with no capture, set out_valid=0. Simultaneous drain and capture replace the entry with no bubble.
- Hold: out_valid && !out_ready keeps every output stable, bit-exact, until accepted.
- Flush: clears out_valid next edge and blocks capture that cycle, regardless of handshakes. Flush has priority over capture.
- Decode by opcode:
  - OP (0110011): funct3/funct7 to ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; op1=rs1, op2=rs2. funct7 must be 0000000, or 0100000 only for ADD->SUB and SRL->SRA.
  - OP-IMM (0010011): same map, op2=imm. SUB is not reachable. SLLI needs funct7=0000000; SRLI/SRAI need 0000000/0100000.
  - LUI: PASS_B, op2=imm (U), rs1_addr=0.
  - AUIPC: ADD, op1=pc, op2=imm.
  - JAL / JALR: ADD, op1=pc, op2=const 4, is_jump=1.
  - LOAD: ADD, rs1+imm(I), is_load=1.
  - STORE: ADD, rs1+imm(S), is_store=1, reg_write=0.
  - BRANCH: BEQ/BNE use SUB, BLT/BGE use SLT, BLTU/BGEU use SLTU; op2=rs2, is_branch=1, reg_write=0. funct3 010/011 is illegal.
- Illegal: any other opcode or bad funct combination gives illegal=1, alu_control=0010, reg_write=0, all class flags 0, out_valid still 1 so the entry can be trapped.
- Fields never used by an opcode (e.g. rs2_addr for I-type) still carry the raw instruction bits.

Test Plan:
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> out_valid=0 and out_pc=RESET_PC immediately, without waiting for a clock edge.
- ADD x3,x1,x2 (0x002081B3), then SUB (0x402081B3), back-to-back with out_ready=1 -> alu_control 0010 then 0110, rs1=1, rs2=2, rd=3, op2_sel=00, one entry per cycle, no bubble.
- SRAI x5,x6,3 (0x40335293) -> alu_control 1010, op2_sel=01, imm=3. ADDI x1,x0,-1 (0xFFF00093) -> ADD, imm=0xFFFFFFFF.
- LUI x1,0x12345 (0x123450B7) -> alu_control 1101, imm=0x12345000, reg_write=1. ADDI x0,x0,0 -> reg_write=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, second instruction captured on the first cycle out_ready=1.
- flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input not captured. Opcode 0x7F -> illegal=1, reg_write=0.
